// File: rtl/sd_dac_pkg.sv
// Shared types and helpers for the stepped sigma-delta DAC.
package sd_dac_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } step_state_t;

  // Entry 0 is the idle level; active entries ramp linearly and clip at full scale.
  function automatic int default_level(input int k, input int idle_level,
                                       input int step_inc, input int width);
    int max_level;
    max_level = (1 << width) - 1;
    if (k == 0) return idle_level;
    if (k * step_inc > max_level) return max_level;
    return k * step_inc;
  endfunction

endpackage

// File: rtl/sd_dac_stepper_if.sv
// Step-table write bus between the configuring master and the DAC.
interface sd_dac_stepper_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             tbl_we;
  logic [AW-1:0]    tbl_addr;
  logic [WIDTH-1:0] tbl_wdata;

  modport master (output tbl_we, tbl_addr, tbl_wdata);
  modport slave  (input  tbl_we, tbl_addr, tbl_wdata);
endinterface

// File: rtl/sd_dac_core.sv
// First-order sigma-delta modulator: accumulator with registered carry as the bitstream.
module sd_dac_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_dac_n,
  input  logic [WIDTH-1:0] level,
  output logic             DACout
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, level};

  always_ff @(posedge clk or negedge rst_dac_n) begin
    if (!rst_dac_n) begin
      acc    <= '0;
      DACout <= 1'b0;
    end else begin
      acc    <= sum[WIDTH-1:0];
      DACout <= sum[WIDTH];
    end
  end

endmodule

// File: rtl/sd_dac_stepper.sv
// Stepped-level sigma-delta DAC: inc_dac synchroniser, dwell timer, step FSM and level table.
//
// state   | meaning
// ST_IDLE | after reset, step 0 (idle level), waiting for first advance
// ST_RUN  | cycling through steps 1..NUM_STEPS
module sd_dac_stepper
  import sd_dac_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_STEPS  = 9,
  parameter int AW         = 4,
  parameter int DWELL_W    = 16,
  parameter int IDLE_LEVEL = 32,
  parameter int STEP_INC   = 4
) (
  input  logic                 clk,
  input  logic                 rst_dac_n,
  input  logic                 inc_dac,
  input  logic                 auto_mode,
  input  logic [DWELL_W-1:0]   dwell,
  sd_dac_stepper_if.slave      tbl,
  output logic                 DACout,
  output logic [AW-1:0]        dac_step,
  output logic [WIDTH-1:0]     dac_level,
  output logic                 step_wrap
);

  localparam logic [AW-1:0]    LAST_STEP = AW'(NUM_STEPS);
  localparam logic [WIDTH-1:0] IDLE_LVL  = WIDTH'(IDLE_LEVEL);

  logic [SYNC_DEPTH-1:0] inc_sync;
  logic                  inc_dly;
  logic                  inc_edge;

  always_ff @(posedge clk or negedge rst_dac_n) begin
    if (!rst_dac_n) begin
      inc_sync <= '0;
      inc_dly  <= 1'b0;
    end else begin
      inc_sync <= {inc_sync[SYNC_DEPTH-2:0], inc_dac};
      inc_dly  <= inc_sync[SYNC_DEPTH-1];
    end
  end

  assign inc_edge = inc_sync[SYNC_DEPTH-1] & ~inc_dly;

  logic [DWELL_W-1:0] dwell_cnt;
  logic               auto_prev;
  logic               auto_hit;
  logic               advance;

  // >= rather than == so a dwell shortened below the running count fires immediately.
  assign auto_hit = auto_mode && (dwell != '0) && (dwell_cnt >= dwell - DWELL_W'(1));
  assign advance  = inc_edge | auto_hit;

  always_ff @(posedge clk or negedge rst_dac_n) begin
    if (!rst_dac_n) begin
      dwell_cnt <= '0;
      auto_prev <= 1'b0;
    end else begin
      auto_prev <= auto_mode;
      if (auto_mode != auto_prev)
        dwell_cnt <= '0;
      else if (auto_mode && advance)
        dwell_cnt <= '0;
      else if (auto_mode && (dwell != '0))
        dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  step_state_t      state, state_nxt;
  logic [AW-1:0]    step_nxt;
  logic             wrap_nxt;

  always_ff @(posedge clk or negedge rst_dac_n) begin
    if (!rst_dac_n) begin
      state     <= ST_IDLE;
      dac_step  <= '0;
      step_wrap <= 1'b0;
    end else begin
      state     <= state_nxt;
      dac_step  <= step_nxt;
      step_wrap <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = dac_step;
    wrap_nxt  = 1'b0;
    if (advance) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_RUN;
          step_nxt  = AW'(1);
        end
        ST_RUN: begin
          if (dac_step == LAST_STEP) begin
            step_nxt = AW'(1);
            wrap_nxt = 1'b1;
          end else begin
            step_nxt = dac_step + AW'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  logic [WIDTH-1:0] tbl_mem [0:NUM_STEPS];
  logic             wr_ok;

  assign wr_ok = tbl.tbl_we && (tbl.tbl_addr <= LAST_STEP);

  always_ff @(posedge clk or negedge rst_dac_n) begin
    if (!rst_dac_n) begin
      for (int k = 0; k <= NUM_STEPS; k++)
        tbl_mem[k] <= WIDTH'(default_level(k, IDLE_LEVEL, STEP_INC, WIDTH));
    end else if (wr_ok) begin
      tbl_mem[tbl.tbl_addr] <= tbl.tbl_wdata;
    end
  end

  // Bypass lets a write to the live step reach the modulator one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_dac_n) begin
    if (!rst_dac_n)
      dac_level <= IDLE_LVL;
    else if (wr_ok && (tbl.tbl_addr == dac_step))
      dac_level <= tbl.tbl_wdata;
    else
      dac_level <= tbl_mem[dac_step];
  end

  sd_dac_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_dac_n (rst_dac_n),
    .level     (dac_level),
    .DACout    (DACout)
  );

endmodule

// File: tb/tb_sd_dac_stepper.sv
// Directed bench for sd_dac_stepper with hand-computed step, level and pulse-density values.
module tb_sd_dac_stepper;

  logic        clk;
  logic        rst_dac_n;
  logic        inc_dac;
  logic        auto_mode;
  logic [15:0] dwell;
  logic        DACout;
  logic [3:0]  dac_step;
  logic [7:0]  dac_level;
  logic        step_wrap;

  int checks;
  int errors;
  int ones;

  sd_dac_stepper_if #(.WIDTH(8), .AW(4)) tbl_bus ();

  sd_dac_stepper dut (
    .clk       (clk),
    .rst_dac_n (rst_dac_n),
    .inc_dac   (inc_dac),
    .auto_mode (auto_mode),
    .dwell     (dwell),
    .tbl       (tbl_bus.slave),
    .DACout    (DACout),
    .dac_step  (dac_step),
    .dac_level (dac_level),
    .step_wrap (step_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic count_ones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += int'(DACout);
    end
  endtask

  // inc_dac high 4 clk then low 4 clk; step moves on the 3rd edge after the rise.
  task automatic pulse_inc(input int prev_step, input int exp_step, input int exp_wrap,
                           input int exp_level);
    inc_dac = 1'b1;
    repeat (2) @(negedge clk);
    check_val("step_before_3rd_edge", int'(dac_step), prev_step);
    @(negedge clk);
    check_val("step_after_advance", int'(dac_step), exp_step);
    check_val("wrap_on_advance", int'(step_wrap), exp_wrap);
    @(negedge clk);
    inc_dac = 1'b0;
    check_val("level_after_step", int'(dac_level), exp_level);
    check_val("wrap_one_cycle", int'(step_wrap), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic tbl_write(input int addr, input int data);
    tbl_bus.tbl_we    = 1'b1;
    tbl_bus.tbl_addr  = 4'(addr);
    tbl_bus.tbl_wdata = 8'(data);
    @(negedge clk);
    tbl_bus.tbl_we    = 1'b0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_dac_n         = 1'b0;
    inc_dac           = 1'b0;
    auto_mode         = 1'b0;
    dwell             = 16'd0;
    tbl_bus.tbl_we    = 1'b0;
    tbl_bus.tbl_addr  = 4'd0;
    tbl_bus.tbl_wdata = 8'd0;

    #12;
    check_val("rst_step", int'(dac_step), 0);
    check_val("rst_level", int'(dac_level), 32);
    check_val("rst_dacout", int'(DACout), 0);
    check_val("rst_wrap", int'(step_wrap), 0);

    @(negedge clk);
    rst_dac_n = 1'b1;
    count_ones(256, ones);
    check_val("idle_ones_256", ones, 32);
    check_val("idle_step_hold", int'(dac_step), 0);

    // Manual walk through all steps and the 9 -> 1 wrap.
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) pulse_inc(9, 1, 1, 4);
      else         pulse_inc(i - 1, i, 0, 4 * i);
    end

    // Auto mode, dwell 5: first advance comes one cycle later because of the mode-change clear.
    dwell     = 16'd5;
    auto_mode = 1'b1;
    repeat (5) @(negedge clk);
    check_val("auto_before_first", int'(dac_step), 1);
    @(negedge clk);
    check_val("auto_first_adv", int'(dac_step), 2);
    repeat (2) @(negedge clk);
    inc_dac = 1'b1;
    repeat (3) @(negedge clk);
    check_val("coinc_single_adv", int'(dac_step), 3);
    @(negedge clk);
    inc_dac = 1'b0;
    repeat (3) @(negedge clk);
    check_val("auto_before_next", int'(dac_step), 3);
    @(negedge clk);
    check_val("auto_next_adv", int'(dac_step), 4);

    dwell = 16'd0;
    repeat (20) @(negedge clk);
    check_val("dwell0_hold", int'(dac_step), 4);
    auto_mode = 1'b0;
    dwell     = 16'd5;
    @(negedge clk);

    // Live step entry rewrite.
    tbl_write(4, 255);
    check_val("wr_live_level", int'(dac_level), 255);
    @(negedge clk);
    count_ones(256, ones);
    check_val("full_scale_ones", ones, 255);

    tbl_write(12, 0);
    @(negedge clk);
    check_val("wr_oob_ignored", int'(dac_level), 255);

    tbl_write(4, 0);
    check_val("level_zero", int'(dac_level), 0);
    @(negedge clk);
    count_ones(300, ones);
    check_val("zero_ones_300", ones, 0);

    tbl_write(4, 128);
    check_val("level_half", int'(dac_level), 128);
    count_ones(256, ones);
    check_val("half_ones_256", ones, 128);
    for (int p = 0; p < 8; p++) begin
      count_ones(2, ones);
      check_val("half_alternate_pair", ones, 1);
    end

    // Reset in the middle of an auto run with a modified table.
    dwell     = 16'd3;
    auto_mode = 1'b1;
    repeat (7) @(negedge clk);
    #2;
    rst_dac_n = 1'b0;
    #1;
    check_val("midrst_step", int'(dac_step), 0);
    check_val("midrst_level", int'(dac_level), 32);
    check_val("midrst_dacout", int'(DACout), 0);
    check_val("midrst_wrap", int'(step_wrap), 0);
    auto_mode = 1'b0;
    dwell     = 16'd0;
    @(negedge clk);
    rst_dac_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_first_dacout", int'(DACout), 0);
    check_val("post_rst_level", int'(dac_level), 32);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++)
      pulse_inc(i - 1, i, 0, 4 * i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
